// File: rtl/fft_mask_pkg.sv
// ---------------------------------------------------------------------------
// fft_mask_pkg
// Shared widths, types and the fixed-point round/saturate helper for the
// FFT mask multiplier pipeline.
//   DEF_DATA_WIDTH : default signed width of re/im, Q1.(DATA_WIDTH-1)
//   DEF_MASK_WIDTH : default signed mask width, Q1.(MASK_WIDTH-1)
//   DEF_NUM_BINS   : default bins per frame
//   cplx_t         : complex sample at the default data width
//   bin_idx_t      : bin index at the default bin count
//   sat_round()    : round-half-up by 'frac' bits, then clip to 'dw' bits
// ---------------------------------------------------------------------------
package fft_mask_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_MASK_WIDTH = 16;
    localparam int DEF_NUM_BINS   = 257;
    localparam int DEF_BIN_W      = $clog2(DEF_NUM_BINS);

    typedef struct packed {
        logic signed [DEF_DATA_WIDTH-1:0] re;
        logic signed [DEF_DATA_WIDTH-1:0] im;
    } cplx_t;

    typedef logic [DEF_BIN_W-1:0] bin_idx_t;

    // Works on a 64-bit sign-extended product so any practical
    // DATA_WIDTH + MASK_WIDTH fits; frac must be at least 1.
    function automatic logic signed [63:0] sat_round(
        input logic signed [63:0] prod,
        input int                 frac,
        input int                 dw
    );
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        r     = (prod + (64'sd1 <<< (frac - 1))) >>> frac;
        max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (dw - 1));
        if (r > max_v) begin
            return max_v;
        end else if (r < min_v) begin
            return min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_mask_mult_pipe_round_sat.sv
// ---------------------------------------------------------------------------
// fft_round_sat
// Combinational round-half-up and saturate of one full-width product.
//   prod_i : signed product, PROD_W bits, FRAC fractional bits
//   res_o  : rounded, clipped result, DATA_W bits
//   ovf_o  : 1 when the rounded value did not fit and was clipped
// ---------------------------------------------------------------------------
module fft_round_sat
    import fft_mask_pkg::*;
#(
    parameter int PROD_W = 32,
    parameter int FRAC   = 15,
    parameter int DATA_W = 16
) (
    input  logic signed [PROD_W-1:0] prod_i,
    output logic signed [DATA_W-1:0] res_o,
    output logic                     ovf_o
);

    logic signed [63:0] prod_ext;
    logic signed [63:0] rounded;
    logic signed [63:0] clipped;

    always_comb begin
        prod_ext = {{(64 - PROD_W){prod_i[PROD_W-1]}}, prod_i};
        rounded  = (prod_ext + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
        clipped  = sat_round(prod_ext, FRAC, DATA_W);
        res_o    = clipped[DATA_W-1:0];
        // Clipping is exactly the case where the clipped value moved.
        ovf_o    = (clipped != rounded);
    end

endmodule

// File: rtl/fft_mask_mult_pipe.sv
// ---------------------------------------------------------------------------
// fft_mask_mult_pipe
// Three-stage pipeline multiplying a complex FFT bin by a real signed mask
// gain, with round-half-up, saturation, per-frame bin numbering and sticky
// saturation/framing flags.
//   clk_i, rst_i          : clock, async active-high reset
//   clr_i                 : sync clear of sticky flags and the bin counter
//   in_valid_i/in_ready_o : input handshake
//   in_re_i, in_im_i      : bin value, mask_i : gain, in_last_i : frame end
//   out_valid_o/out_ready_i : output handshake
//   out_re_o, out_im_o    : masked bin, out_bin_o : bin index,
//   out_last_o            : out_bin_o is the final bin of a frame
//   sat_o, frame_err_o    : sticky flags
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. All stages move together when the output register is empty or
// being drained (en); in_ready_o is that same enable, so a stall holds every
// stage, bubbles included, and the output stays stable until taken.
// ---------------------------------------------------------------------------
module fft_mask_mult_pipe
    import fft_mask_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MASK_WIDTH = DEF_MASK_WIDTH,
    parameter int NUM_BINS   = DEF_NUM_BINS,
    localparam int BIN_W     = $clog2(NUM_BINS)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic signed [DATA_WIDTH-1:0] in_re_i,
    input  logic signed [DATA_WIDTH-1:0] in_im_i,
    input  logic signed [MASK_WIDTH-1:0] mask_i,
    input  logic                         in_last_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic signed [DATA_WIDTH-1:0] out_re_o,
    output logic signed [DATA_WIDTH-1:0] out_im_o,
    output logic [BIN_W-1:0]             out_bin_o,
    output logic                         out_last_o,
    output logic                         sat_o,
    output logic                         frame_err_o
);

    localparam int FRAC   = MASK_WIDTH - 1;
    localparam int PROD_W = DATA_WIDTH + MASK_WIDTH;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

    logic                         en;
    logic                         accept;

    logic                         v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [DATA_WIDTH-1:0] s1_re_q, s1_re_d, s1_im_q, s1_im_d;
    logic signed [MASK_WIDTH-1:0] s1_mask_q, s1_mask_d;
    logic [BIN_W-1:0]             s1_bin_q, s1_bin_d;
    logic signed [PROD_W-1:0]     s2_pre_q, s2_pre_d, s2_pim_q, s2_pim_d;
    logic [BIN_W-1:0]             s2_bin_q, s2_bin_d;
    logic signed [DATA_WIDTH-1:0] s3_re_q, s3_re_d, s3_im_q, s3_im_d;
    logic [BIN_W-1:0]             s3_bin_q, s3_bin_d;
    logic [BIN_W-1:0]             cnt_q, cnt_d, cnt_inc;
    logic                         sat_q, sat_d;
    logic                         ferr_q, ferr_d;

    logic signed [PROD_W-1:0]     prod_re, prod_im;
    logic signed [DATA_WIDTH-1:0] rnd_re, rnd_im;
    logic                         ovf_re, ovf_im;

    assign en         = !v3_q || out_ready_i;
    assign accept     = in_valid_i && en;
    assign in_ready_o = en;

    // Operands are sign-extended to the full product width by context.
    assign prod_re = s1_re_q * s1_mask_q;
    assign prod_im = s1_im_q * s1_mask_q;

    fft_round_sat #(
        .PROD_W (PROD_W),
        .FRAC   (FRAC),
        .DATA_W (DATA_WIDTH)
    ) u_round_sat_re (
        .prod_i (s2_pre_q),
        .res_o  (rnd_re),
        .ovf_o  (ovf_re)
    );

    fft_round_sat #(
        .PROD_W (PROD_W),
        .FRAC   (FRAC),
        .DATA_W (DATA_WIDTH)
    ) u_round_sat_im (
        .prod_i (s2_pim_q),
        .res_o  (rnd_im),
        .ovf_o  (ovf_im)
    );

    always_comb begin
        v1_d      = v1_q;
        v2_d      = v2_q;
        v3_d      = v3_q;
        s1_re_d   = s1_re_q;
        s1_im_d   = s1_im_q;
        s1_mask_d = s1_mask_q;
        s1_bin_d  = s1_bin_q;
        s2_pre_d  = s2_pre_q;
        s2_pim_d  = s2_pim_q;
        s2_bin_d  = s2_bin_q;
        s3_re_d   = s3_re_q;
        s3_im_d   = s3_im_q;
        s3_bin_d  = s3_bin_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        ferr_d    = ferr_q;
        cnt_inc   = (cnt_q == LAST_BIN) ? '0 : cnt_q + BIN_W'(1);

        if (en) begin
            v1_d = accept;
            v2_d = v1_q;
            v3_d = v2_q;
            if (accept) begin
                s1_re_d   = in_re_i;
                s1_im_d   = in_im_i;
                s1_mask_d = mask_i;
                // A clear in the accept cycle numbers this sample as bin 0.
                s1_bin_d  = clr_i ? '0 : cnt_q;
            end
            if (v1_q) begin
                s2_pre_d = prod_re;
                s2_pim_d = prod_im;
                s2_bin_d = s1_bin_q;
            end
            if (v2_q) begin
                s3_re_d  = rnd_re;
                s3_im_d  = rnd_im;
                s3_bin_d = s2_bin_q;
                if (ovf_re || ovf_im) begin
                    sat_d = 1'b1;
                end
            end
        end

        if (accept) begin
            if (clr_i) begin
                cnt_d = BIN_W'(1);
            end else if (in_last_i && (cnt_q != LAST_BIN)) begin
                // Early frame end: flag it and resync to a new frame.
                ferr_d = 1'b1;
                cnt_d  = '0;
            end else begin
                if (!in_last_i && (cnt_q == LAST_BIN)) begin
                    ferr_d = 1'b1;
                end
                cnt_d = cnt_inc;
            end
        end else if (clr_i) begin
            cnt_d = '0;
        end

        // Clear has priority over a same-cycle flag set.
        if (clr_i) begin
            sat_d  = 1'b0;
            ferr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            s1_re_q   <= '0;
            s1_im_q   <= '0;
            s1_mask_q <= '0;
            s1_bin_q  <= '0;
            s2_pre_q  <= '0;
            s2_pim_q  <= '0;
            s2_bin_q  <= '0;
            s3_re_q   <= '0;
            s3_im_q   <= '0;
            s3_bin_q  <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            v3_q      <= v3_d;
            s1_re_q   <= s1_re_d;
            s1_im_q   <= s1_im_d;
            s1_mask_q <= s1_mask_d;
            s1_bin_q  <= s1_bin_d;
            s2_pre_q  <= s2_pre_d;
            s2_pim_q  <= s2_pim_d;
            s2_bin_q  <= s2_bin_d;
            s3_re_q   <= s3_re_d;
            s3_im_q   <= s3_im_d;
            s3_bin_q  <= s3_bin_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            ferr_q    <= ferr_d;
        end
    end

    assign out_valid_o = v3_q;
    assign out_re_o    = s3_re_q;
    assign out_im_o    = s3_im_q;
    assign out_bin_o   = s3_bin_q;
    assign out_last_o  = (s3_bin_q == LAST_BIN);
    assign sat_o       = sat_q;
    assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_fft_mask_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_fft_mask_mult_pipe
// Directed bench for fft_mask_mult_pipe (16-bit data and mask, 4 bins per
// frame). The driver pushes the hand-computed response of every accepted
// sample; a negedge monitor pops and compares each output transfer and
// checks that stalled outputs stay put.
// ---------------------------------------------------------------------------
module tb_fft_mask_mult_pipe;

    localparam int DW = 16;
    localparam int MW = 16;
    localparam int NB = 4;
    localparam int BW = 2;
    localparam int EW = DW + DW + BW + 1;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 clr_i = 1'b0;
    logic                 in_valid_i = 1'b0;
    logic                 in_ready_o;
    logic signed [DW-1:0] in_re_i = '0;
    logic signed [DW-1:0] in_im_i = '0;
    logic signed [MW-1:0] mask_i = '0;
    logic                 in_last_i = 1'b0;
    logic                 out_valid_o;
    logic                 out_ready_i = 1'b1;
    logic signed [DW-1:0] out_re_o;
    logic signed [DW-1:0] out_im_o;
    logic [BW-1:0]        out_bin_o;
    logic                 out_last_o;
    logic                 sat_o;
    logic                 frame_err_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic bp_mode = 1'b0;

    logic [EW-1:0] exp_q[$];
    int            lat_q[$];

    fft_mask_mult_pipe #(
        .DATA_WIDTH (DW),
        .MASK_WIDTH (MW),
        .NUM_BINS   (NB)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .clr_i       (clr_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_re_i     (in_re_i),
        .in_im_i     (in_im_i),
        .mask_i      (mask_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_re_o    (out_re_o),
        .out_im_o    (out_im_o),
        .out_bin_o   (out_bin_o),
        .out_last_o  (out_last_o),
        .sat_o       (sat_o),
        .frame_err_o (frame_err_o)
    );

    // ---------------- clock / reset / backpressure ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ready pattern 1,0,0 repeating while backpressure is on.
    int bp_k = 0;
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            out_ready_i = (bp_k % 3 == 0);
            bp_k++;
        end else begin
            out_ready_i = 1'b1;
            bp_k = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im,
                        input logic [MW-1:0] mask, input logic last, input logic clr,
                        input logic [DW-1:0] ere, input logic [DW-1:0] eim,
                        input logic [BW-1:0] ebin, input logic chk_lat);
        int n;
        @(negedge clk);
        in_valid_i = 1'b1;
        in_re_i    = re;
        in_im_i    = im;
        mask_i     = mask;
        in_last_i  = last;
        clr_i      = clr;
        n = 0;
        while (!in_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("accept_timeout", 64'(n), 64'd0);
        end else begin
            exp_q.push_back({ere, eim, ebin, (ebin == BW'(NB - 1))});
            lat_q.push_back(chk_lat ? cyc + 1 : -1);
        end
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        clr_i      = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_i = 1'b1;
        @(posedge clk);
        #1;
        clr_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic          held_valid = 1'b0;
    logic [EW-1:0] held_v;

    always @(negedge clk) begin
        logic [EW-1:0] cur;
        logic [EW-1:0] e;
        int acc;
        cur = {out_re_o, out_im_o, out_bin_o, out_last_o};
        if (rst_i) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                check("stall_hold", 64'({out_valid_o, cur}), 64'({1'b1, held_v}));
            end
            if (out_valid_o) begin
                if (out_ready_i) begin
                    held_valid = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 64'(cur), 64'd0);
                    end else begin
                        e   = exp_q.pop_front();
                        acc = lat_q.pop_front();
                        check("out_re_im_bin_last", 64'(cur), 64'(e));
                        if (acc >= 0) begin
                            check("latency", 64'(cyc + 1 - acc), 64'd3);
                        end
                    end
                end else begin
                    held_v     = cur;
                    held_valid = 1'b1;
                end
            end else begin
                held_valid = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        #23;
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_sat", 64'(sat_o), 64'd0);
        check("rst_frame_err", 64'(frame_err_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);

        // Basic gain, then saturation / rounding corners, one full frame.
        send(16'h4000, 16'hC000, 16'h4000, 1'b0, 1'b0, 16'h2000, 16'hE000, 2'd0, 1'b1);
        drain();
        check("basic_sat", 64'(sat_o), 64'd0);
        send(16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b0, 16'h7FFF, 16'h0000, 2'd1, 1'b1);
        send(16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 16'h7FFE, 16'h0001, 2'd2, 1'b1);
        send(16'h0001, 16'hFFFF, 16'h4000, 1'b1, 1'b0, 16'h0001, 16'h0000, 2'd3, 1'b1);
        drain();
        check("sat_set", 64'(sat_o), 64'd1);
        check("frame_ok", 64'(frame_err_o), 64'd0);
        pulse_clr();
        @(negedge clk);
        check("clr_sat", 64'(sat_o), 64'd0);

        // Backpressure: 10 samples, gain 0.5, last on bins 3.
        bp_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(DW'(i * 256), DW'(-i * 256), 16'h4000, (i % 4 == 3), 1'b0,
                 DW'(i * 128), DW'(-i * 128), BW'(i % 4), 1'b0);
        end
        drain();
        bp_mode = 1'b0;
        check("bp_frame_ok", 64'(frame_err_o), 64'd0);
        check("bp_sat", 64'(sat_o), 64'd0);

        // Clear with accept gets bin 0; early last resyncs the counter.
        send(16'h1000, 16'h1000, 16'h4000, 1'b0, 1'b1, 16'h0800, 16'h0800, 2'd0, 1'b1);
        send(16'h1000, 16'h2000, 16'h4000, 1'b1, 1'b0, 16'h0800, 16'h1000, 2'd1, 1'b1);
        send(16'h0200, 16'h0400, 16'h4000, 1'b0, 1'b0, 16'h0100, 16'h0200, 2'd0, 1'b1);
        send(16'h0200, 16'h0400, 16'h4000, 1'b0, 1'b0, 16'h0100, 16'h0200, 2'd1, 1'b1);
        drain();
        check("early_last_err", 64'(frame_err_o), 64'd1);
        pulse_clr();
        @(negedge clk);
        check("clr_frame_err", 64'(frame_err_o), 64'd0);

        // Missing last at bin 3 flags an error and wraps normally.
        for (int i = 0; i < 5; i++) begin
            send(16'h0100, 16'h0100, 16'h4000, 1'b0, 1'b0, 16'h0080, 16'h0080, BW'(i % 4), 1'b1);
        end
        drain();
        check("missing_last_err", 64'(frame_err_o), 64'd1);

        // Reset mid-stream after two accepts.
        send(16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h7FFF, 2'd1, 1'b1);
        drain();
        check("sat_im", 64'(sat_o), 64'd1);
        send(16'h0100, 16'h0100, 16'h4000, 1'b0, 1'b0, 16'h0080, 16'h0080, 2'd2, 1'b1);
        send(16'h0100, 16'h0100, 16'h4000, 1'b0, 1'b0, 16'h0080, 16'h0080, 2'd3, 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid_o), 64'd0);
        check("midrst_sat", 64'(sat_o), 64'd0);
        check("midrst_frame_err", 64'(frame_err_o), 64'd0);
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        send(16'h2000, 16'h0003, 16'h7FFF, 1'b0, 1'b0, 16'h2000, 16'h0003, 2'd0, 1'b1);
        drain();
        check("post_rst_sat", 64'(sat_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
